// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings, default latencies and FSM states for the multiply/divide unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_way_valid(input logic [2:0] w);
        return (w <= MD_DIVU);
    endfunction

    function automatic logic md_way_is_mult(input logic [2:0] w);
        return (w == MD_MULT) || (w == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide datapath producing HI/LO results and a divide-by-zero flag
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [2:0]  way,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] abs_b_safe;
    logic [31:0] w2_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{w1[31]}}, w1} * {{32{w2[31]}}, w2};
    assign prod_u = {32'd0, w1} * {32'd0, w2};

    assign sign_a     = w1[31];
    assign sign_b     = w2[31];
    assign abs_a      = sign_a ? (32'd0 - w1) : w1;
    assign abs_b      = sign_b ? (32'd0 - w2) : w2;
    // Divisors of zero are replaced so the dividers never see zero; the result is discarded anyway.
    assign abs_b_safe = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign w2_safe    = (w2 == 32'd0) ? 32'd1 : w2;
    assign q_mag      = abs_a / abs_b_safe;
    assign r_mag      = abs_a % abs_b_safe;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (way)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                // Magnitude divide then re-sign: quotient truncates toward zero, remainder follows dividend.
                res_lo = (sign_a ^ sign_b) ? (32'd0 - q_mag) : q_mag;
                res_hi = sign_a ? (32'd0 - r_mag) : r_mag;
                div0   = (w2 == 32'd0);
            end
            MD_DIVU: begin
                res_lo = w1 / w2_safe;
                res_hi = w1 % w2_safe;
                div0   = (w2 == 32'd0);
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
                div0   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning the architectural HI/LO registers
module muldiv_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [2:0]  way,
    input  logic        start,
    input  logic        HIw,
    input  logic        LOw,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    md_state_e   state;
    md_state_e   state_next;
    logic [CW-1:0] count;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_div0;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;
    logic        accept;
    logic        commit;
    logic        hl_write;

    md_calc u_calc (
        .w1     (w1),
        .w2     (w2),
        .way    (way),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start in IDLE, even with a reserved way, suppresses any HI/LO write in that cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        hl_write   = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    if (md_way_valid(way)) begin
                        accept     = 1'b1;
                        state_next = MD_RUN;
                    end
                end else begin
                    hl_write = 1'b1;
                end
            end
            MD_RUN: begin
                if (count == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            if (accept) begin
                pend_hi   <= res_hi;
                pend_lo   <= res_lo;
                pend_div0 <= div0;
                count     <= md_way_is_mult(way) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (state == MD_RUN) begin
                count <= count - CW'(1);
            end

            if (commit) begin
                if (!pend_div0) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else if (hl_write) begin
                if (HIw) hi <= w1;
                if (LOw) lo <= w1;
            end
        end
    end

    assign busy = (state == MD_RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [2:0]  way;
    logic        start;
    logic        HIw;
    logic        LOw;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .w1    (w1),
        .w2    (w2),
        .way   (way),
        .start (start),
        .HIw   (HIw),
        .LOw   (LOw),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: architectural outcome of one operation; returns expected busy length.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int n);
        logic [63:0] p;
        int ia;
        int ib;
        ia = a;
        ib = b;
        n  = 0;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
                n = 5;
            end
            3'd1: begin
                p = 64'(a) * 64'(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
                n = 5;
            end
            3'd2: begin
                n = 10;
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = ia / ib;
                        m_hi = ia % ib;
                    end
                end
            end
            3'd3: begin
                n = 10;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: n = 0;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inj, input bit lo_at_start);
        int n;
        int exp_n;
        @(negedge clk);
        way   = op;
        w1    = a;
        w2    = b;
        start = 1'b1;
        LOw   = lo_at_start;
        @(negedge clk);
        start = 1'b0;
        LOw   = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (inj && n == 2) begin
                start = 1'b1;
                HIw   = 1'b1;
                way   = 3'($urandom_range(0, 3));
                w1    = 32'hDEAD_0000;
            end else begin
                start = 1'b0;
                HIw   = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        HIw   = 1'b0;
        model_op(op, a, b, exp_n);
        chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    task automatic write_hl(input string tag, input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        HIw = h;
        LOw = l;
        w1  = v;
        @(negedge clk);
        HIw = 1'b0;
        LOw = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        w1 = 32'd0; w2 = 32'd0; way = 3'd0; start = 1'b0; HIw = 1'b0; LOw = 1'b0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu", 3'd3, 32'd7, 32'd2, 1'b0, 1'b0);

        write_hl("mthi", 1'b1, 1'b0, 32'h1111_1111);
        write_hl("mtlo", 1'b0, 1'b1, 32'h2222_2222);
        run_op("div0", 3'd2, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("divu0", 3'd3, 32'd9, 32'd0, 1'b0, 1'b0);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        run_op("inj_run", 3'd0, 32'd3, 32'd4, 1'b1, 1'b0);
        run_op("start_low", 3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        run_op("reserved", 3'd5, 32'd1, 32'd1, 1'b0, 1'b0);
        write_hl("mthi_only", 1'b1, 1'b0, 32'hABCD_1234);
        write_hl("both", 1'b1, 1'b1, 32'hCAFE_F00D);

        // Asynchronous reset landing between edges in the third busy cycle.
        @(negedge clk);
        way = 3'd0; w1 = 32'd6; w2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.hi", hi, 32'd0);
        chk("mid_rst.lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        run_op("after_rst", 3'd0, 32'd6, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                write_hl("rnd_wr", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else if (r == 1) begin
                run_op("rnd_res", 3'($urandom_range(4, 7)), pick(), pick(), 1'b0, 1'b0);
            end else begin
                run_op("rnd_op", 3'($urandom_range(0, 3)), pick(), pick(),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide responder for the P7 pipeline.
- Sits behind the Execute stage's start/busy handshake and owns the architectural HI/LO registers.
- Accepts an operation pulse, holds `busy` for a fixed latency, then commits the result to HI/LO.
- Also services direct HI/LO writes (mthi/mtlo); Execute reads `hi`/`lo` for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- w1  in  32  operand A (rs); also data for HIw/LOw
- w2  in  32  operand B (rt)
- way  in  3  operation select, sampled only when start=1
- start  in  1  one-cycle request pulse; already gated by the requester against exception/eret
- HIw  in  1  write w1 into HI
- LOw  in  1  write w1 into LO
- busy  out  1  operation in progress
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result cleared, state=IDLE.
  - Applies immediately, including mid-operation; the in-flight result is discarded.
- way encoding:
  - 0 = mult (signed)
  - 1 = multu
  - 2 = div (signed)
  - 3 = divu
  - 4-7 = reserved: start is ignored and the unit stays IDLE.
- States: IDLE and RUN.
- IDLE, start=1 with valid way:
  - Compute the result from w1/w2 and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, state=IDLE.
  - Net effect: busy is high for exactly N cycles. The new hi/lo are visible in the first cycle busy reads 0.
- Mult: 64-bit product; hi=[63:32], lo=[31:0]. Signed or unsigned per way.
- Div: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- Divide by zero:
  - Full DIV_CYCLES busy period still runs.
  - At completion hi/lo stay unchanged; pending values are not committed.
- HIw/LOw:
  - Honoured only in IDLE with start=0. The write takes effect on the same edge, so hi/lo show the new value next cycle.
  - HIw and LOw may both be 1; both registers then get w1.
- Simultaneous events:
  - start and HIw/LOw in the same IDLE cycle: start wins, the write is dropped.
  - start, HIw or LOw while RUN: ignored (the pipeline stalls md instructions while busy|start). The in-flight operation is not restarted.
  - Back-to-back: start may be accepted in the first cycle after busy falls.
- `hi`/`lo` are driven directly from the registers, with no combinational path from the inputs.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES))+1.

Decomposition:
- Shared package (md_pkg) holds:
  - way encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - default latency constants;
  - the state enum {MD_IDLE, MD_RUN}.
- One combinational sub-module, md_calc:
  - inputs w1, w2, way;
  - outputs res_hi, res_lo, div0 flag;
  - owns all signed/unsigned arithmetic.
- The top level holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- Signed multiply:
  - Reset, then start way=0, w1=0xFFFFFFFF, w2=2.
  - busy=1 for exactly 5 cycles.
  - When busy falls: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned multiply:
  - Same operands with way=1.
  - hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- Signed and unsigned divide:
  - way=2, w1=0xFFFFFFF9 (-7), w2=2: after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - way=3, w1=7, w2=2: lo=3, hi=1.
- Divide by zero:
  - Preload hi=0x11111111, lo=0x22222222 via HIw/LOw.
  - Start div with w2=0: busy for 10 cycles, then hi/lo unchanged.
  - Also check 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Collisions during and at start:
  - Pulse start and HIw (w1=0xDEAD0000) during RUN: ignored, the original result commits.
  - Start and LOw in the same IDLE cycle: LOw dropped.
  - HIw alone in IDLE: hi=w1 next cycle.
- Reset mid-operation:
  - Assert reset low at busy cycle 3 of a mult, asynchronously and between edges.
  - busy, hi and lo drop to 0 immediately.
  - After release, a fresh start works normally with busy for 5 cycles.
